sqrt_cpu: RTL and testbench



---
 rtl/sqrt_cpu.sv | 182 ++++++++++++++++++
 tb/tb_sqrt_cpu.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/sqrt_cpu.sv
// Purpose : sequenced core computing round(sqrt(X)) of a 16-bit operand held in internal data memory.
// Latency : Ack rises on the 13th rising Clk edge after the edge that samples Start low; fixed for every X.
// Backpr. : none; Start is a level request (high = abort/arm, falling = launch), Ack holds until Start rises.
//
// Ports:
//   Clk   - single clock, all state changes on the rising edge
//   Reset - asynchronous active-low reset (Core contents are not cleared)
//   Start - program request; held high while operands load, dropped to launch
//   Ack   - registered completion flag, high only in DONE
//
// Build option: define SQRT_FLOOR_EN to return floor(sqrt(X)) instead of the
// rounded value; the ROUND cycle is kept so latency does not change.
//
// Memory map: operand high byte at OPND_ADDR, low byte at OPND_ADDR+1,
// result byte at RES_ADDR. Only RES_ADDR is ever written by the core.

module sqrt_dm #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          Clk,
  input  logic [AW-1:0] addr,
  input  logic          wr_vld,
  input  logic [7:0]    wr_dat,
  output logic [7:0]    rd_dat
);
  // Host preloads and reads back through this array hierarchically.
  logic [7:0] Core [0:DEPTH-1];

  always_ff @(posedge Clk) begin
    if (wr_vld) Core[addr] <= wr_dat;
  end

  assign rd_dat = Core[addr];
endmodule

module sqrt_cpu #(
  parameter int DM_DEPTH  = 256,
  parameter int OPND_ADDR = 16,
  parameter int RES_ADDR  = 18
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Start,
  output logic Ack
);
  localparam int AW = $clog2(DM_DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] LOAD_HI = 3'd1;
  localparam logic [2:0] LOAD_LO = 3'd2;
  localparam logic [2:0] ITER    = 3'd3;
  localparam logic [2:0] ROUND   = 3'd4;
  localparam logic [2:0] STORE   = 3'd5;
  localparam logic [2:0] DONE    = 3'd6;

  logic [2:0]    state;
  logic          armed;
  logic          ack_q;
  logic [15:0]   opnd;
  logic [9:0]    rem;
  logic [7:0]    root;
  logic [2:0]    cnt;

  logic [AW-1:0] dm_addr;
  logic          dm_wr_vld;
  logic [7:0]    dm_rd_dat;

  // One restoring step: bring down the next two operand bits and try
  // subtracting (4*root + 1). Remainder never exceeds 2*root, so 10 bits
  // hold it; the 12-bit temporaries cover the shifted-in intermediate.
  logic [11:0] rem_sh;
  logic [11:0] trial;
  logic [11:0] diff;
  logic [9:0]  rem_nxt;
  logic [7:0]  root_nxt;
  logic        do_round;
  logic        unused_bits;

  always_comb begin
    rem_sh   = {rem, opnd[15:14]};
    trial    = {2'b00, root, 2'b01};
    diff     = rem_sh - trial;
    rem_nxt  = rem_sh[9:0];
    root_nxt = {root[6:0], 1'b0};
    if (rem_sh >= trial) begin
      rem_nxt  = diff[9:0];
      root_nxt = {root[6:0], 1'b1};
    end
  end

  assign unused_bits = ^{rem_sh[11:10], diff[11:10]};

`ifdef SQRT_FLOOR_EN
  assign do_round = 1'b0;
`else
  // X - r*r > r means sqrt(X) > r + 0.5; saturate instead of wrapping at 255.
  assign do_round = (rem > {2'b00, root}) && (root != 8'hFF);
`endif

  always_comb begin
    dm_addr = AW'(RES_ADDR);
    case (state)
      LOAD_HI: dm_addr = AW'(OPND_ADDR);
      LOAD_LO: dm_addr = AW'(OPND_ADDR + 1);
      default: dm_addr = AW'(RES_ADDR);
    endcase
  end

  // A Start during STORE aborts, so the result write is suppressed too.
  assign dm_wr_vld = (state == STORE) && !Start;

  sqrt_dm #(.DEPTH(DM_DEPTH), .AW(AW)) DM1 (
    .Clk    (Clk),
    .addr   (dm_addr),
    .wr_vld (dm_wr_vld),
    .wr_dat (root),
    .rd_dat (dm_rd_dat)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      armed <= 1'b0;
      ack_q <= 1'b0;
      opnd  <= '0;
      rem   <= '0;
      root  <= '0;
      cnt   <= '0;
    end else begin
      // Ack follows DONE by one edge, which makes up the 13-edge latency.
      ack_q <= (state == DONE) && !Start;
      if (Start) begin
        // Start high aborts whatever is running and arms the next launch.
        state <= IDLE;
        armed <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (armed) begin
              state <= LOAD_HI;
              armed <= 1'b0;
            end
          end
          LOAD_HI: begin
            opnd[15:8] <= dm_rd_dat;
            state      <= LOAD_LO;
          end
          LOAD_LO: begin
            opnd[7:0] <= dm_rd_dat;
            rem       <= '0;
            root      <= '0;
            cnt       <= '0;
            state     <= ITER;
          end
          ITER: begin
            opnd <= {opnd[13:0], 2'b00};
            rem  <= rem_nxt;
            root <= root_nxt;
            cnt  <= cnt + 3'd1;
            if (cnt == 3'd7) state <= ROUND;
          end
          ROUND: begin
            if (do_round) root <= root + 8'd1;
            state <= STORE;
          end
          STORE: begin
            state <= DONE;
          end
          DONE: begin
            state <= DONE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  assign Ack = ack_q;
endmodule

// File: tb/tb_sqrt_cpu.sv
// Purpose : self-checking bench for sqrt_cpu using a result scoreboard.
// Latency : checks the fixed 13-edge Start-low to Ack latency on every run.
// Backpr. : drives Start as a level, waits on Ack with a bounded cycle budget.

module tb_sqrt_cpu;
  logic Clk = 1'b0;
  logic Reset;
  logic Start;
  logic Ack;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q [$];

  always #5 Clk = ~Clk;

  sqrt_cpu dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Start (Start),
    .Ack   (Ack)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: linear search for floor sqrt, then round and saturate.
  function automatic logic [7:0] model(input logic [15:0] x);
    int r;
    int rem;
    r = 0;
    while ((r + 1) * (r + 1) <= int'(x)) r++;
    rem = int'(x) - r * r;
`ifndef SQRT_FLOOR_EN
    if (rem > r) r++;
`endif
    if (r > 255) r = 255;
    return r[7:0];
  endfunction

  // Loads X, holds Start for two cycles, drops it and returns just after
  // the edge that samples Start low.
  task automatic launch(input logic [15:0] x);
    @(negedge Clk);
    dut.DM1.Core[16] <= x[15:8];
    dut.DM1.Core[17] <= x[7:0];
    Start = 1'b1;
    repeat (2) @(negedge Clk);
    Start = 1'b0;
    @(posedge Clk);
  endtask

  task automatic wait_ack(output int lat);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      if (Ack === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic run(input string tag, input logic [15:0] x);
    int lat;
    logic [7:0] e;
    launch(x);
    exp_q.push_back(model(x));
    wait_ack(lat);
    check({tag, "_lat"}, lat, 13);
    e = exp_q.pop_front();
    check(tag, {24'd0, dut.DM1.Core[18]}, {24'd0, e});
  endtask

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    dut.DM1.Core[18] <= 8'h5A;
    dut.DM1.Core[19] <= 8'hA5;
    #9;
    check("rst_ack", {31'd0, Ack}, 32'd0);
    #1;
    Reset = 1'b1;

    // No arming since reset: Start low must not launch anything.
    repeat (20) @(negedge Clk);
    check("unarmed_ack", {31'd0, Ack}, 32'd0);
    check("unarmed_res", {24'd0, dut.DM1.Core[18]}, 32'h5A);

    run("x144", 16'd144);
    run("x0", 16'd0);
    run("x2", 16'd2);
    run("x3", 16'd3);
    run("x240", 16'd240);
    run("x241", 16'd241);
    run("x65280", 16'd65280);
    run("x65281", 16'd65281);
    run("x65535", 16'd65535);
    check("keep16", {24'd0, dut.DM1.Core[16]}, 32'hFF);
    check("keep17", {24'd0, dut.DM1.Core[17]}, 32'hFF);
    check("keep19", {24'd0, dut.DM1.Core[19]}, 32'hA5);

    // Ack holds in DONE while Start stays low, drops one edge after Start rises.
    repeat (5) @(negedge Clk);
    check("ack_hold", {31'd0, Ack}, 32'd1);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    check("ack_drop", {31'd0, Ack}, 32'd0);
    run("x625", 16'd625);

    // Asynchronous reset clears Ack without waiting for a clock edge.
    @(negedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("ack_async", {31'd0, Ack}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;

    // Abort during ITER: result byte must keep its previous value.
    launch(16'd65535);
    repeat (6) @(posedge Clk);
    #2;
    Reset = 1'b0;
    #1;
    check("abort_ack", {31'd0, Ack}, 32'd0);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    repeat (20) @(negedge Clk);
    check("abort_keep", {24'd0, dut.DM1.Core[18]}, 32'h19);
    check("abort_idle", {31'd0, Ack}, 32'd0);

    run("relaunch", 16'd144);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
